// File: rtl/tick_object_mover.sv
// rtl/tick_object_mover.sv - per-tick object mover with erase/update/draw plot handshake; TICK_OBJECT_MOVER_BOUNCE_EN reflects at edges
module tick_object_mover #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [3:0] vel_x,
    input  logic [3:0] vel_y,
    input  logic       enable,
    output logic       plot_req,
    output logic       plot_erase,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    input  logic       plot_ack,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y,
    output logic       busy,
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
    output logic       bounce,
`endif
    output logic       tick_overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ERASE  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_DRAW   = 2'd3;

    localparam logic signed [8:0] W9    = 9'(SCREEN_W);
    localparam logic signed [7:0] H8    = 8'(SCREEN_H);
    localparam logic signed [8:0] X_MAX = 9'(SCREEN_W - 1);
    localparam logic signed [7:0] Y_MAX = 8'(SCREEN_H - 1);

    logic [1:0]        state;
    logic              pending;
    logic              ack_ok;
    logic              start;
    logic              plotting;
    logic [3:0]        vx_eff;
    logic [3:0]        vy_eff;
    logic signed [8:0] sum_x;
    logic signed [7:0] sum_y;
    logic [7:0]        new_x;
    logic [6:0]        new_y;

    assign plotting = (state == S_ERASE) || (state == S_DRAW);
    // plot_req is only ever high in ERASE/DRAW, so this also ignores acks in IDLE/UPDATE
    assign ack_ok   = plotting && plot_req && plot_ack;
    assign start    = (state == S_IDLE) && (tick || pending) && enable;
    assign busy     = (state != S_IDLE);

`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
    logic flip_x;
    logic flip_y;
    logic refl_x;
    logic refl_y;

    function automatic logic [3:0] neg_sat(input logic [3:0] v);
        return (v == 4'b1000) ? 4'b0111 : (~v + 4'd1);
    endfunction

    assign vx_eff = flip_x ? neg_sat(vel_x) : vel_x;
    assign vy_eff = flip_y ? neg_sat(vel_y) : vel_y;
    assign bounce = (state == S_UPDATE) && (refl_x || refl_y);
`else
    assign vx_eff = vel_x;
    assign vy_eff = vel_y;
`endif

    assign sum_x = $signed({1'b0, pos_x}) + $signed({{5{vx_eff[3]}}, vx_eff});
    assign sum_y = $signed({1'b0, pos_y}) + $signed({{4{vy_eff[3]}}, vy_eff});

    // |vel| is below either screen size, so one correction always lands on screen
    always_comb begin
        new_x = 8'(sum_x);
        new_y = 7'(sum_y);
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
        refl_x = 1'b0;
        refl_y = 1'b0;
        if (sum_x < 9'sd0) begin
            new_x  = 8'd0;
            refl_x = 1'b1;
        end else if (sum_x > X_MAX) begin
            new_x  = 8'(X_MAX);
            refl_x = 1'b1;
        end
        if (sum_y < 8'sd0) begin
            new_y  = 7'd0;
            refl_y = 1'b1;
        end else if (sum_y > Y_MAX) begin
            new_y  = 7'(Y_MAX);
            refl_y = 1'b1;
        end
`else
        if (sum_x < 9'sd0)
            new_x = 8'(sum_x + W9);
        else if (sum_x >= W9)
            new_x = 8'(sum_x - W9);
        if (sum_y < 8'sd0)
            new_y = 7'(sum_y + H8);
        else if (sum_y >= H8)
            new_y = 7'(sum_y - H8);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pos_x        <= 8'(X_INIT);
            pos_y        <= 7'(Y_INIT);
            plot_req     <= 1'b0;
            plot_erase   <= 1'b0;
            plot_x       <= 8'd0;
            plot_y       <= 7'd0;
            pending      <= 1'b0;
            tick_overrun <= 1'b0;
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
            flip_x       <= 1'b0;
            flip_y       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_ERASE;
                        plot_x <= pos_x;
                        plot_y <= pos_y;
                    end
                end
                S_ERASE: begin
                    if (ack_ok)
                        state <= S_UPDATE;
                end
                S_UPDATE: begin
                    pos_x  <= new_x;
                    pos_y  <= new_y;
                    plot_x <= new_x;
                    plot_y <= new_y;
                    state  <= S_DRAW;
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
                    if (refl_x)
                        flip_x <= ~flip_x;
                    if (refl_y)
                        flip_y <= ~flip_y;
`endif
                end
                S_DRAW: begin
                    if (ack_ok)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            plot_req   <= plotting && !ack_ok;
            plot_erase <= (state == S_ERASE) && !ack_ok;

            if (start) begin
                pending <= 1'b0;
            end else if (busy && tick) begin
                if (pending)
                    tick_overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end
            // a dead object must not resume from a tick queued during its last move
            if ((state == S_DRAW) && ack_ok && !enable)
                pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tick_object_mover.sv
// tb/tb_tick_object_mover.sv - randomized and directed bench for tick_object_mover against a behavioural model
module tb_tick_object_mover;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [3:0] vel_x;
    logic [3:0] vel_y;
    logic       enable;
    logic       plot_req;
    logic       plot_erase;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic       plot_ack;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       busy;
    logic       tick_overrun;
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
    logic       bounce;
`endif

    always #5 clk = ~clk;

    tick_object_mover dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .vel_x        (vel_x),
        .vel_y        (vel_y),
        .enable       (enable),
        .plot_req     (plot_req),
        .plot_erase   (plot_erase),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .plot_ack     (plot_ack),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .busy         (busy),
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
        .bounce       (bounce),
`endif
        .tick_overrun (tick_overrun)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: phase 0 idle, 1 erase, 2 update, 3 draw; age = cycles spent in phase
    bit model_valid = 0;
    int m_phase, m_age, m_x, m_y;
    bit m_pend, m_ovr, m_fx, m_fy;

    int  ack_delay = 0;
    int  req_age = 0;
    bit  tick_on_draw_ack = 0;
    bit  no_draw_ack = 0;
    int  n_erase = 0, n_draw = 0, busy_cnt = 0, bounce_cnt = 0;
    int  er_x, er_y, dr_x, dr_y;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_req();
        return (m_phase == 1 || m_phase == 3) && m_age >= 1;
    endfunction

`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
    function automatic int reflect_axis(input int p, input int v, input int size,
                                        inout bit flip, output bit refl);
        int e;
        int n;
        e = flip ? ((v == -8) ? 7 : -v) : v;
        n = p + e;
        refl = 0;
        if (n < 0) begin
            n = 0; flip = !flip; refl = 1;
        end else if (n > size - 1) begin
            n = size - 1; flip = !flip; refl = 1;
        end
        return n;
    endfunction
`else
    function automatic int wrap_axis(input int p, input int v, input int size);
        return ((p + v) % size + size) % size;
    endfunction
`endif

    task automatic check_outputs();
        if (!model_valid)
            return;
        check("busy", busy, m_phase != 0);
        check("plot_req", plot_req, exp_req());
        check("pos_x", pos_x, m_x);
        check("pos_y", pos_y, m_y);
        check("tick_overrun", tick_overrun, m_ovr);
        if (exp_req()) begin
            check("plot_erase", plot_erase, m_phase == 1);
            check("plot_x", plot_x, m_x);
            check("plot_y", plot_y, m_y);
        end
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
        begin
            bit fx, fy, rx, ry;
            int tmp;
            fx = m_fx; fy = m_fy; rx = 0; ry = 0;
            if (m_phase == 2) begin
                tmp = reflect_axis(m_x, int'($signed(vel_x)), 160, fx, rx);
                tmp = reflect_axis(m_y, int'($signed(vel_y)), 120, fy, ry);
            end
            check("bounce", bounce, rx | ry);
        end
`endif
    endtask

    task automatic model_step();
        bit er;
        int nph;
        if (!reset_n) begin
            m_phase = 0; m_age = 0; m_x = 80; m_y = 60;
            m_pend = 0; m_ovr = 0; m_fx = 0; m_fy = 0;
            model_valid = 1;
            return;
        end
        if (!model_valid)
            return;
        er  = exp_req();
        nph = m_phase;
        case (m_phase)
            0: if ((tick || m_pend) && enable) begin nph = 1; m_pend = 0; end
            1: if (plot_ack && er) nph = 2;
            2: begin
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
                bit rx, ry;
                m_x = reflect_axis(m_x, int'($signed(vel_x)), 160, m_fx, rx);
                m_y = reflect_axis(m_y, int'($signed(vel_y)), 120, m_fy, ry);
`else
                m_x = wrap_axis(m_x, int'($signed(vel_x)), 160);
                m_y = wrap_axis(m_y, int'($signed(vel_y)), 120);
`endif
                nph = 3;
            end
            3: if (plot_ack && er) nph = 0;
            default: ;
        endcase
        if (m_phase != 0 && tick) begin
            if (m_pend) m_ovr = 1;
            else m_pend = 1;
        end
        if (m_phase == 3 && nph == 0 && !enable)
            m_pend = 0;
        m_age   = (nph == m_phase) ? m_age + 1 : 0;
        m_phase = nph;
    endtask

    // one clock: compare at negedge, arbiter answers, model advances just after the edge
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        if (busy) busy_cnt++;
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
        if (bounce) bounce_cnt++;
`endif
        plot_ack = 0;
        if (plot_req) begin
            req_age++;
            if (ack_delay < 0)
                plot_ack = ($urandom_range(0, 2) == 0);
            else
                plot_ack = (req_age > ack_delay);
            if (no_draw_ack && !plot_erase)
                plot_ack = 0;
        end else begin
            req_age = 0;
        end
        if (plot_ack) begin
            if (plot_erase) begin
                n_erase++; er_x = plot_x; er_y = plot_y;
            end else begin
                n_draw++; dr_x = plot_x; dr_y = plot_y;
                if (tick_on_draw_ack) begin
                    tick = 1;
                    tick_on_draw_ack = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        model_step();
        tick = 0;
        plot_ack = 0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((m_phase != 0 || m_pend) && k < 300) begin
            cycle();
            k++;
        end
        check("idle_timeout", (m_phase == 0 && !m_pend), 1);
    endtask

    task automatic move();
        tick = 1;
        cycle();
        wait_idle();
    endtask

    initial begin
        int e0, d0, k;
        reset_n = 0; tick = 0; enable = 1; vel_x = 0; vel_y = 0; plot_ack = 0;
        cycle();
        cycle();
        check("rst_plot_req", plot_req, 0);
        check("rst_plot_erase", plot_erase, 0);
        check("rst_plot_x", plot_x, 0);
        check("rst_plot_y", plot_y, 0);
        check("rst_pos_x", pos_x, 80);
        check("rst_pos_y", pos_y, 60);
        check("rst_busy", busy, 0);
        reset_n = 1;
        cycle();

        // first move, immediate acks
        vel_x = 4'd3; vel_y = 4'b1110; busy_cnt = 0;
        move();
        check("t1_erase_x", er_x, 80);
        check("t1_erase_y", er_y, 60);
        check("t1_draw_x", dr_x, 83);
        check("t1_draw_y", dr_y, 58);
        check("t1_pos_x", pos_x, 83);
        check("t1_pos_y", pos_y, 58);
        check("t1_busy_cycles", busy_cnt, 5);

        vel_y = 4'd0; vel_x = 4'd7;
        repeat (10) move();
`ifdef TICK_OBJECT_MOVER_BOUNCE_EN
        vel_x = 4'd4; move();
        check("b_pos_x_157", pos_x, 157);
        vel_x = 4'd7; bounce_cnt = 0;
        move();
        check("b_pos_x_159", pos_x, 159);
        check("b_bounce_pulses", bounce_cnt, 1);
        move();
        check("b_pos_x_152", pos_x, 152);
`else
        vel_x = 4'd5; move();
        check("w_pos_x_158", pos_x, 158);
        move();
        check("w_pos_x_3", pos_x, 3);
        vel_x = 4'd0; vel_y = 4'b1001;
        repeat (8) move();
        vel_y = 4'hF; move();
        check("w_pos_y_1", pos_y, 1);
        vel_y = 4'hC; move();
        check("w_pos_y_117", pos_y, 117);
`endif

        // three ticks while erase ack is held off
        vel_x = 4'd1; vel_y = 4'd1; ack_delay = 20; d0 = n_draw;
        tick = 1; cycle();
        repeat (3) cycle();
        tick = 1; cycle();
        repeat (3) cycle();
        tick = 1; cycle();
        wait_idle();
        check("ovr_flag", tick_overrun, 1);
        check("ovr_draws", n_draw - d0, 2);
        ack_delay = 0;

        // tick coincident with draw ack
        e0 = n_erase;
        tick = 1; cycle();
        tick_on_draw_ack = 1;
        k = 0;
        while (tick_on_draw_ack && k < 50) begin cycle(); k++; end
        check("tda_ack_seen", tick_on_draw_ack, 0);
        check("tda_idle_gap", busy, 0);
        cycle();
        check("tda_restart", busy, 1);
        wait_idle();
        check("tda_erases", n_erase - e0, 2);

        // reset while draw request is outstanding
        no_draw_ack = 1;
        tick = 1; cycle();
        k = 0;
        while (!(m_phase == 3 && exp_req()) && k < 50) begin cycle(); k++; end
        check("rd_reached_draw", (m_phase == 3 && exp_req()), 1);
        reset_n = 0;
        cycle();
        reset_n = 1;
        no_draw_ack = 0;
        check("rd_plot_req", plot_req, 0);
        check("rd_busy", busy, 0);
        check("rd_pos_x", pos_x, 80);
        check("rd_pos_y", pos_y, 60);
        check("rd_overrun", tick_overrun, 0);

        // randomized traffic
        ack_delay = -1;
        repeat (3000) begin
            tick    = ($urandom_range(0, 5) == 0);
            enable  = ($urandom_range(0, 15) != 0);
            vel_x   = 4'($urandom_range(0, 15));
            vel_y   = 4'($urandom_range(0, 15));
            reset_n = ($urandom_range(0, 599) != 0);
            cycle();
            reset_n = 1;
        end
        enable = 1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
